// File: rtl/ysyx_24070016_trap_seq.sv
// Trap/return sequencer: owns the CSR port while busy, writes mepc/mcause,
// read-modify-writes mstatus, then pulses a PC redirect to mtvec or mepc.
module ysyx_24070016_trap_seq #(
  parameter logic [31:0] CAUSE_ECALL   = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK  = 32'd3,
  parameter logic [31:0] CAUSE_ILLEGAL = 32'd2,
  parameter logic [1:0]  MPP_RET       = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [31:0] req_pc,
  output logic [1:0]  csr_op,
  output logic [31:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [1:0]  KindEcall   = 2'b00;
  localparam logic [1:0]  KindEbreak  = 2'b01;
  localparam logic [1:0]  KindMret    = 2'b11;
  localparam logic [1:0]  OpIdle      = 2'b00;
  localparam logic [1:0]  OpWrite     = 2'b01;
  localparam logic [31:0] AddrMstatus = 32'h0000_0300;
  localparam logic [31:0] AddrMepc    = 32'h0000_0341;
  localparam logic [31:0] AddrMcause  = 32'h0000_0342;

  typedef enum logic [2:0] {
    StIdle,
    StWMepc,
    StWMcause,
    StRMst,
    StWMst,
    StRedir
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [29:0] pc_q, pc_d;
  logic [31:0] mst_q, mst_d;

  logic        is_mret;
  logic [31:0] cause;
  logic [31:0] mst_upd;

  // mtvec mode bits are ignored (direct mode only).
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^csr_mtvec[1:0];

  assign is_mret = (kind_q == KindMret);

  always_comb begin
    cause = CAUSE_ILLEGAL;
    if (kind_q == KindEcall) begin
      cause = CAUSE_ECALL;
    end else if (kind_q == KindEbreak) begin
      cause = CAUSE_EBREAK;
    end
  end

  // mstatus field updates; every other bit of the captured value is preserved.
  always_comb begin
    mst_upd = mst_q;
    if (is_mret) begin
      mst_upd[3]     = mst_q[7];
      mst_upd[7]     = 1'b1;
      mst_upd[12:11] = MPP_RET;
    end else begin
      mst_upd[7]     = mst_q[3];
      mst_upd[3]     = 1'b0;
      mst_upd[12:11] = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      kind_q  <= 2'b00;
      pc_q    <= '0;
      mst_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      mst_q   <= mst_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    pc_d           = pc_q;
    mst_d          = mst_q;
    req_ready      = 1'b0;
    busy           = 1'b1;
    csr_op         = OpIdle;
    csr_addr       = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          kind_d  = req_kind;
          pc_d    = req_pc[31:2];
          state_d = (req_kind == KindMret) ? StRMst : StWMepc;
        end
      end
      StWMepc: begin
        csr_op    = OpWrite;
        csr_addr  = AddrMepc;
        csr_wdata = {pc_q, 2'b00};
        state_d   = StWMcause;
      end
      StWMcause: begin
        csr_op    = OpWrite;
        csr_addr  = AddrMcause;
        csr_wdata = cause;
        state_d   = StRMst;
      end
      StRMst: begin
        csr_addr = AddrMstatus;
        mst_d    = csr_rdata;
        state_d  = StWMst;
      end
      StWMst: begin
        csr_op    = OpWrite;
        csr_addr  = AddrMstatus;
        csr_wdata = mst_upd;
        state_d   = StRedir;
      end
      StRedir: begin
        redirect_valid = 1'b1;
        redirect_pc    = is_mret ? csr_mepc : {csr_mtvec[31:2], 2'b00};
        state_d        = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_24070016_trap_seq.sv
// Bench for the trap sequencer: a small CSR file model plus directed vectors,
// random transactions against a spec-level model, and reset/back-pressure cases.
module tb_ysyx_24070016_trap_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [31:0] req_pc;
  logic [1:0]  csr_op;
  logic [31:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24070016_trap_seq dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_kind      (req_kind),
    .req_pc        (req_pc),
    .csr_op        (csr_op),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata),
    .csr_mtvec     (csr_mtvec),
    .csr_mepc      (csr_mepc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy)
  );

  // CSR file model: one write port, combinational read, preload path for the bench.
  logic [31:0] m_mstatus, m_mepc, m_mcause, m_mtvec;
  logic        load_en;
  logic [31:0] ld_mstatus, ld_mepc, ld_mcause, ld_mtvec;

  always @(posedge clk) begin
    if (load_en) begin
      m_mstatus <= ld_mstatus;
      m_mepc    <= ld_mepc;
      m_mcause  <= ld_mcause;
      m_mtvec   <= ld_mtvec;
    end else if (csr_op == 2'b01) begin
      case (csr_addr)
        32'h300: m_mstatus <= csr_wdata;
        32'h305: m_mtvec   <= csr_wdata;
        32'h341: m_mepc    <= csr_wdata;
        32'h342: m_mcause  <= csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      32'h300: csr_rdata = m_mstatus;
      32'h305: csr_rdata = m_mtvec;
      32'h341: csr_rdata = m_mepc;
      32'h342: csr_rdata = m_mcause;
      default: csr_rdata = 32'h0;
    endcase
  end

  assign csr_mtvec = m_mtvec;
  assign csr_mepc  = m_mepc;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] mst;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] exp_mepc;
    logic [31:0] exp_mcause;
    logic [31:0] exp_mst;
    logic [31:0] exp_redir;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] mst, input logic [31:0] mtvec,
                         input logic [31:0] mepc, input logic [31:0] mcause);
    @(negedge clk);
    ld_mstatus = mst;
    ld_mtvec   = mtvec;
    ld_mepc    = mepc;
    ld_mcause  = mcause;
    load_en    = 1'b1;
    @(negedge clk);
    load_en    = 1'b0;
  endtask

  // Architectural outcome of one trap/mret computed from the field rules.
  task automatic model(input logic [1:0] kind, input logic [31:0] pc, input logic [31:0] mst,
                       input logic [31:0] mtvec, input logic [31:0] mepc,
                       input logic [31:0] mcause, output logic [31:0] e_mepc,
                       output logic [31:0] e_mcause, output logic [31:0] e_mst,
                       output logic [31:0] e_redir, output int lat);
    if (kind == 2'b11) begin
      e_mst    = (mst & ~32'h1888) | 32'h1800 | 32'h80 | (((mst >> 7) & 32'd1) << 3);
      e_mepc   = mepc;
      e_mcause = mcause;
      e_redir  = mepc;
      lat      = 3;
    end else begin
      e_mst    = (mst & ~32'h1888) | 32'h1800 | (((mst >> 3) & 32'd1) << 7);
      e_mepc   = pc & ~32'd3;
      e_mcause = (kind == 2'b00) ? 32'd11 : (kind == 2'b01) ? 32'd3 : 32'd2;
      e_redir  = mtvec & ~32'd3;
      lat      = 5;
    end
  endtask

  // Issue one request from a preloaded CSR state and check timing and final CSRs.
  task automatic run_txn(input string tag, input vec_t v, input logic [31:0] mcause0);
    int first;
    int pulses;
    logic ready_low_ok;
    logic ready_back;
    logic [31:0] rpc;
    preload(v.mst, v.mtvec, v.mepc, mcause0);
    req_valid = 1'b1;
    req_kind  = v.kind;
    req_pc    = v.pc;
    chk({tag, ".ready_idle"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    first        = -1;
    pulses       = 0;
    ready_low_ok = 1'b1;
    ready_back   = 1'b0;
    rpc          = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (redirect_valid) begin
        pulses++;
        if (first < 0) begin
          first = k;
          rpc   = redirect_pc;
        end
      end
      if (k <= v.lat && (req_ready || !busy)) ready_low_ok = 1'b0;
      if (k == v.lat + 1) ready_back = req_ready && !busy;
    end
    chk({tag, ".redir_cycle"}, first, v.lat);
    chk({tag, ".redir_pulses"}, pulses, 32'd1);
    chk({tag, ".redir_pc"}, rpc, v.exp_redir);
    chk({tag, ".busy_window"}, {31'd0, ready_low_ok}, 32'd1);
    chk({tag, ".ready_back"}, {31'd0, ready_back}, 32'd1);
    chk({tag, ".mepc"}, m_mepc, v.exp_mepc);
    chk({tag, ".mcause"}, m_mcause, v.exp_mcause);
    chk({tag, ".mstatus"}, m_mstatus, v.exp_mst);
  endtask

  vec_t vecs[5];

  initial begin
    vec_t rv;
    int   pulsed;
    logic [31:0] mc0;

    vecs[0] = '{2'b00, 32'h8000_0010, 32'h0000_0008, 32'h8000_1000, 32'h0,
                32'h8000_0010, 32'd11, 32'h0000_1880, 32'h8000_1000, 5};
    vecs[1] = '{2'b11, 32'h8000_0014, 32'h0000_1880, 32'h8000_1000, 32'h8000_0014,
                32'h8000_0014, 32'd0, 32'h0000_1888, 32'h8000_0014, 3};
    vecs[2] = '{2'b01, 32'h8000_0020, 32'h0000_0008, 32'h8000_1003, 32'h0,
                32'h8000_0020, 32'd3, 32'h0000_1880, 32'h8000_1000, 5};
    vecs[3] = '{2'b10, 32'h8000_0033, 32'h0000_0000, 32'h8000_1003, 32'h0,
                32'h8000_0030, 32'd2, 32'h0000_1800, 32'h8000_1000, 5};
    vecs[4] = '{2'b00, 32'h8000_0040, 32'hFFFF_0008, 32'h8000_1000, 32'h0,
                32'h8000_0040, 32'd11, 32'hFFFF_1880, 32'h8000_1000, 5};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_kind  = 2'b00;
    req_pc    = 32'h0;
    load_en   = 1'b0;
    ld_mstatus = 32'h0;
    ld_mtvec   = 32'h0;
    ld_mepc    = 32'h0;
    ld_mcause  = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset.req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.csr_op", {30'd0, csr_op}, 32'd0);
    chk("reset.csr_addr", csr_addr, 32'd0);
    chk("reset.csr_wdata", csr_wdata, 32'd0);
    chk("reset.redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset.redirect_pc", redirect_pc, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i], 32'h0);
    end

    for (int i = 0; i < 30; i++) begin
      rv.kind  = 2'($urandom_range(0, 3));
      rv.pc    = $urandom;
      rv.mst   = $urandom;
      rv.mtvec = $urandom;
      rv.mepc  = $urandom;
      mc0      = $urandom;
      model(rv.kind, rv.pc, rv.mst, rv.mtvec, rv.mepc, mc0,
            rv.exp_mepc, rv.exp_mcause, rv.exp_mst, rv.exp_redir, rv.lat);
      run_txn($sformatf("rand%0d", i), rv, mc0);
    end

    // Reset asserted while in W_MCAUSE.
    preload(32'h0000_0008, 32'h8000_1000, 32'h0, 32'h0);
    req_valid = 1'b1;
    req_kind  = 2'b00;
    req_pc    = 32'h8000_0100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.csr_op", {30'd0, csr_op}, 32'd0);
    rst = 1'b1;
    pulsed = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (redirect_valid) pulsed++;
    end
    chk("midrst.no_redirect", pulsed, 32'd0);
    chk("midrst.mepc_kept", m_mepc, 32'h8000_0100);
    chk("midrst.mstatus_untouched", m_mstatus, 32'h0000_0008);

    // Request held valid across a busy sequence; second one accepted only after REDIR.
    preload(32'h0000_0008, 32'h8000_2000, 32'h0, 32'h0);
    req_valid = 1'b1;
    req_kind  = 2'b00;
    req_pc    = 32'h8000_0200;
    @(posedge clk);
    pulsed = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_kind = 2'b01;
        req_pc   = 32'h8000_0306;
      end
      if (k <= 5 && req_ready) pulsed++;
      if (k == 6) chk("held.ready_after_redir", {31'd0, req_ready}, 32'd1);
    end
    chk("held.ready_low", pulsed, 32'd0);
    chk("held.first_mcause", m_mcause, 32'd11);
    @(posedge clk);
    pulsed = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (redirect_valid && pulsed < 0) begin
        pulsed = k;
        chk("held.second_redir_pc", redirect_pc, 32'h8000_2000);
      end
    end
    chk("held.second_redir_cycle", pulsed, 32'd5);
    chk("held.second_mepc", m_mepc, 32'h8000_0304);
    chk("held.second_mcause", m_mcause, 32'd3);
    chk("held.second_mstatus", m_mstatus, 32'h0000_1800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
